divider_64: RTL

DIVIDER_64 -- requirements
Module: divider_64

---
 rtl/divider_64_pkg.sv | 35 +++
 rtl/divider_64_if.sv | 20 ++
 rtl/divider_64_step.sv | 37 +++
 rtl/divider_64.sv | 118 +++++++++++
 4 files changed

// File: rtl/divider_64_pkg.sv
// Shared types and constants for the 64-bit restoring divider.
// Build option: define DIVIDER_ZERO_FASTPATH_EN to finish divide-by-zero in one cycle.
`ifndef DIVIDER_64_PKG_SV
`define DIVIDER_64_PKG_SV

package common;
  typedef logic [63:0]  word_t;
  typedef logic [64:0]  word65_t;
  typedef logic [127:0] u128;
endpackage

package pipes;
  localparam int DIV_ITERS = 64;
  localparam int DIV_CNT_W = $clog2(DIV_ITERS + 1);
endpackage

package divider_64_pkg;
  typedef common::word_t   word_t;
  typedef common::word65_t word65_t;
  typedef common::u128     u128;

  localparam int DIV_ITERS = pipes::DIV_ITERS;
  localparam int DIV_CNT_W = pipes::DIV_CNT_W;

  typedef logic [DIV_CNT_W-1:0] cnt_t;

  localparam word_t ALL_ONES = '1;

  // Result layout: remainder in the upper word, quotient in the lower word.
  function automatic u128 pack_result(input word_t rem, input word_t quot);
    return {rem, quot};
  endfunction
endpackage

`endif

// File: rtl/divider_64_if.sv
// Request/response bundle for divider_64.
// Build option: DIVIDER_ZERO_FASTPATH_EN (affects the divider, not this bundle).
`ifndef DIVIDER_64_IF_SV
`define DIVIDER_64_IF_SV

interface divider_64_if;
  import divider_64_pkg::*;

  logic  valid;
  word_t a;
  word_t b;
  logic  busy;
  logic  done;
  u128   c;

  modport master (output valid, a, b, input busy, done, c);
  modport slave  (input valid, a, b, output busy, done, c);
endinterface

`endif

// File: rtl/divider_64_step.sv
// One restoring-division iteration: shift {rem, quot} left by one, trial-subtract
// the divisor, keep the difference and set the quotient bit when it does not go negative.
// Build option: DIVIDER_ZERO_FASTPATH_EN (not used here).
`ifndef DIVIDER_64_STEP_SV
`define DIVIDER_64_STEP_SV

module divider_step
  import divider_64_pkg::*;
(
  input  word65_t rem_in,
  input  word_t   quot_in,
  input  word_t   divisor,
  output word65_t rem_out,
  output word_t   quot_out
);

  // The partial remainder never exceeds the divisor, so rem_in's top bit is always
  // zero; carrying it one bit wider keeps the borrow of the trial subtraction exact.
  logic [65:0] shifted;
  logic [65:0] diff;

  // Trial subtraction and restore decision for a single quotient bit.
  always_comb begin
    shifted = {rem_in, quot_in[63]};
    diff    = shifted - {2'b00, divisor};
    if (!diff[65]) begin
      rem_out  = diff[64:0];
      quot_out = {quot_in[62:0], 1'b1};
    end else begin
      rem_out  = shifted[64:0];
      quot_out = {quot_in[62:0], 1'b0};
    end
  end

endmodule

`endif

// File: rtl/divider_64.sv
// Unsigned 64-bit restoring divider, one quotient bit per cycle, MSB first.
// c = {remainder, quotient}; divide-by-zero yields quotient all-ones, remainder = a.
// Build option DIVIDER_ZERO_FASTPATH_EN: a zero divisor completes IDLE->DONE in one edge.
`ifndef DIVIDER_64_SV
`define DIVIDER_64_SV

module divider_64
  import divider_64_pkg::*;
(
  input logic         clk,
  input logic         reset,
  divider_64_if.slave dif
);

  typedef enum logic [1:0] {
    IDLE,
    DOING,
    DONE
  } state_t;

  state_t  state;
  state_t  state_next;
  word65_t rem_q;
  word65_t rem_next;
  word_t   quot_q;
  word_t   quot_next;
  word_t   divisor_q;
  cnt_t    count_q;
  u128     c_q;
  logic    zero_fast;
  logic    last_iter;

  divider_step u_step (
    .rem_in   (rem_q),
    .quot_in  (quot_q),
    .divisor  (divisor_q),
    .rem_out  (rem_next),
    .quot_out (quot_next)
  );

`ifdef DIVIDER_ZERO_FASTPATH_EN
  assign zero_fast = (state == IDLE) && dif.valid && (dif.b == '0);
`else
  assign zero_fast = 1'b0;
`endif

  assign last_iter = (count_q == cnt_t'(1));

  // State register, cleared by the synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: requests are only taken in IDLE; DONE always returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (dif.valid) begin
          state_next = zero_fast ? DONE : DOING;
        end
      end
      DOING: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate in DOING, capture the result on the last iteration.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      count_q   <= '0;
      c_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dif.valid) begin
            rem_q     <= '0;
            quot_q    <= dif.a;
            divisor_q <= dif.b;
            count_q   <= cnt_t'(DIV_ITERS);
            if (zero_fast) begin
              c_q <= pack_result(dif.a, ALL_ONES);
            end
          end
        end
        DOING: begin
          rem_q   <= rem_next;
          quot_q  <= quot_next;
          count_q <= count_q - cnt_t'(1);
          if (last_iter) begin
            c_q <= pack_result(rem_next[63:0], quot_next);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dif.busy = (state != IDLE);
  assign dif.done = (state == DONE);
  assign dif.c    = c_q;

endmodule

`endif
